queue_serializer: RTL and testbench
===================================

# queue_serializer

Downstream consumer of the message queue: pops one `msg_width`-bit message at a time via the queue's read handshake and emits it as a stream of narrower `beat_width`-bit beats under valid/ready flow control. It drives the queue's `read_ack` input and samples its `read_en` and `read` outputs. It sits between the queue and the narrow display/link side of the design, and it backs off and retries when the queue reports empty.

## Interface
Parameters:
- `msg_width`, 16, width of one queued message
- `beat_width`, 4, width of one output beat; `beats = ceil(msg_width / beat_width)`
- `retry_delay`, 3, idle cycles after an empty pop before the next pop request (≥1)

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `q_data`  in  `msg_width`  message from the queue's `read` output
- `q_valid`  in  1  queue's `read_en`: pop succeeded, `q_data` valid
- `q_pop`  out  1  to the queue's `read_ack`: one-cycle pop request
- `out_data`  out  `beat_width`  current beat
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  sink accepts beat
- `out_last`  out  1  current beat is the final beat of the message
- `busy`  out  1  a message is latched and not fully sent
- `msg_count`  out  16  messages fully sent, wraps at 2^16

## Operation
- FSM states: REQ, WAIT, SEND, BACKOFF. Reset state is REQ.
- REQ: `q_pop`=1 for exactly this cycle; next state is WAIT.
- WAIT: sample `q_valid`. If it is 1, latch `q_data` into the shift register, clear the beat index, and go to SEND. If it is 0, load the backoff counter with `retry_delay` and go to BACKOFF.
- BACKOFF: the counter decrements each cycle; when it reaches 1, go to REQ. Exactly `retry_delay` cycles are spent in BACKOFF.
- SEND: `out_valid`=1 and `busy`=1.
  - `out_data` is message bits `[i*beat_width +: beat_width]`, LSB beat first.
  - In the final beat, bits beyond `msg_width` read as 0.
  - `out_last`=1 only when i = beats-1.
  - On `out_valid && out_ready`: if it is the last beat, increment `msg_count` and go to REQ; otherwise i++.
- `out_data`, `out_last` and the latched message are stable while `out_valid && !out_ready`.
- `q_data` is ignored outside WAIT. `q_valid` is ignored outside WAIT. The queue is never popped while a message is held.
- `msg_count` increment is modulo 2^16 (0xFFFF→0x0000).

## Timing
- Reset (sampled high at an edge):
  - state goes to REQ and the backoff counter and beat index clear.
  - `q_pop`, `out_valid`, `out_last`, `busy` and `out_data` go to 0, and `msg_count` goes to 0.
  - `q_pop` is forced to 0 while `reset` is high. The first `q_pop` occurs in the first cycle after reset deasserts.
- Queue response latency is fixed at 1 cycle: `q_valid`/`q_data` are sampled the cycle after `q_pop`.
- Latency: `q_pop` at cycle n, sampling at n+1, first `out_valid` at n+2.
- Throughput with `out_ready` held 1: one message per `beats+2` cycles. The next `q_pop` is the cycle after the last-beat handshake.
- Empty queue: consecutive `q_pop` pulses are spaced `retry_delay+2` cycles apart.
- Reset mid-SEND: the held message is discarded and not counted, and `out_valid` is 0 on the following cycle.
- `out_ready` high outside SEND has no effect.

## Configuration
- `QUEUE_SERIALIZER_PARITY_EN` defined:
  - adds the port `out_parity  out  1`, which equals the XOR of `out_data` (even parity over beat plus parity bit).
  - `out_parity` is valid with `out_valid`, 0 at reset, and stable under backpressure.
- `QUEUE_SERIALIZER_PARITY_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset held 2 cycles, then released: all outputs are 0 during reset, and `q_pop`=1 in the first cycle after release and for only that cycle.
- Defaults, `q_valid`=1 and `q_data`=16'hA5C3 at WAIT, `out_ready`=1: beats 3, C, 5, A appear on consecutive cycles with `out_last` only on A. `msg_count` goes 0→1 and `q_pop` is reasserted the next cycle.
- `q_valid`=0 at every WAIT: `out_valid` never rises, and `q_pop` pulses every 5 cycles (`retry_delay`=3).
- 16'hA5C3 with `out_ready`=0 for 3 cycles during beat index 1: `out_data` holds C for 4 cycles, then the sequence continues with 5, A. `msg_count` ends at 1.
- `msg_width`=10, `beat_width`=4, `q_data`=10'h3FF: 3 beats F, F, 3 with `out_last` on the third. With the parity macro defined, `out_parity` reads 0, 0, 0.
- Reset asserted after beat 0 is accepted: `out_valid`=0 and `msg_count`=0 after the edge, then a fresh `q_pop` the cycle after release.

Source files
------------

// File: rtl/queue_serializer.sv
`default_nettype none
// ============================================================================
// Module      : queue_serializer
// Description : Pops one MSG_WIDTH-bit message from the message queue using
//               its one-cycle read handshake. Replays the message as a stream
//               of BEAT_WIDTH-bit beats, LSB beat first, under valid/ready
//               flow control. When the queue reports empty, the block waits
//               RETRY_DELAY cycles and then requests again.
//
// Parameters  : MSG_WIDTH   - width of one queued message
//               BEAT_WIDTH  - width of one output beat
//               RETRY_DELAY - idle cycles after an empty pop (>= 1)
//
// Ports       : clock      in   sole clock, rising edge
//               reset      in   synchronous, active-high
//               q_data     in   message from the queue read port
//               q_valid    in   queue read_en: pop succeeded, q_data valid
//               q_pop      out  queue read_ack: one-cycle pop request
//               out_data   out  current beat
//               out_valid  out  beat valid
//               out_ready  in   sink accepts beat
//               out_last   out  current beat is the final beat of the message
//               busy       out  a message is held and not fully sent
//               msg_count  out  messages fully sent, wraps at 2^16
//               out_parity out  XOR of out_data (only with
//                               QUEUE_SERIALIZER_PARITY_EN defined)
//
// Options     : QUEUE_SERIALIZER_PARITY_EN - adds the out_parity port
//
// Revision    : 1.0 - initial release
// ============================================================================
module queue_serializer #(
    parameter int MSG_WIDTH   = 16,
    parameter int BEAT_WIDTH  = 4,
    parameter int RETRY_DELAY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [MSG_WIDTH-1:0]  q_data,
    input  logic                  q_valid,
    output logic                  q_pop,
    output logic [BEAT_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           msg_count
`ifdef QUEUE_SERIALIZER_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_BEATS = (MSG_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
    // The message is held zero-extended to a whole number of beats so the
    // final (partial) beat reads 0 above MSG_WIDTH without extra masking.
    localparam int c_PAD_W = c_BEATS * BEAT_WIDTH;
    localparam int c_IDX_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_CNT_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BEATS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_CNT_W-1:0] c_RETRY    = c_CNT_W'(RETRY_DELAY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_SEND    = 2'd2,
        S_BACKOFF = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [c_PAD_W-1:0]   r_msg;        // shift register, current beat in LSBs
    logic [c_IDX_W-1:0]   r_idx;        // index of the beat being presented
    logic [c_CNT_W-1:0]   r_cnt;        // backoff cycles remaining
    logic [15:0]          r_msg_count;

    logic [c_PAD_W-1:0]   w_msg_pad;
    logic                 w_last;

    // ------------------------------------------------------------------------
    // Zero-extension of the incoming message to whole beats
    // ------------------------------------------------------------------------
    generate
        if (c_PAD_W > MSG_WIDTH) begin : g_pad
            assign w_msg_pad = {{(c_PAD_W - MSG_WIDTH){1'b0}}, q_data};
        end else begin : g_no_pad
            assign w_msg_pad = q_data;
        end
    endgenerate

    assign w_last = (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        q_pop        = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b0;
        out_data     = '0;

        case (r_state)
            S_REQ: begin
                // The state already reads REQ while reset is still high, so
                // the pop is gated off until reset is released.
                q_pop        = !reset;
                w_next_state = S_WAIT;
            end

            S_WAIT: begin
                // The queue answers exactly one cycle after the pop.
                w_next_state = q_valid ? S_SEND : S_BACKOFF;
            end

            S_BACKOFF: begin
                if (r_cnt <= c_CNT_ONE) begin
                    w_next_state = S_REQ;
                end
            end

            S_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = r_msg[BEAT_WIDTH-1:0];
                out_last  = w_last;
                if (out_ready && w_last) begin
                    w_next_state = S_REQ;
                end
            end

            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: message shift register, beat index, backoff and message count
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_msg       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_msg_count <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (q_valid) begin
                        r_msg <= w_msg_pad;
                        r_idx <= '0;
                    end else begin
                        r_cnt <= c_RETRY;
                    end
                end

                S_BACKOFF: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end

                S_SEND: begin
                    // Nothing moves without a handshake, which keeps the
                    // beat, its last flag and its parity stable under stall.
                    if (out_ready) begin
                        if (w_last) begin
                            r_msg_count <= r_msg_count + 16'd1;
                        end else begin
                            r_msg <= r_msg >> BEAT_WIDTH;
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign msg_count = r_msg_count;

`ifdef QUEUE_SERIALIZER_PARITY_EN
    // out_data is forced to 0 outside SEND, so parity is 0 there as well.
    assign out_parity = ^out_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_serializer
// Description : Self-checking bench for queue_serializer. A 16/4 instance gets
//               directed and random messages. A 10/4 instance covers the
//               partial final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_serializer;

    localparam int MW = 16;
    localparam int BW = 4;
    localparam int RD = 3;
    localparam int NB = (MW + BW - 1) / BW;

    logic        clock = 1'b0;
    logic        reset;

    logic [15:0] q_data;
    logic        q_valid;
    logic        q_pop;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] msg_count;

    logic [9:0]  q_data10;
    logic        q_valid10;
    logic        q_pop10;
    logic [3:0]  out_data10;
    logic        out_valid10;
    logic        out_ready10;
    logic        out_last10;
    logic        busy10;
    logic [15:0] msg_count10;

`ifdef QUEUE_SERIALIZER_PARITY_EN
    logic        out_parity;
    logic        out_parity10;
`endif

    int total     = 0;
    int bad       = 0;
    int exp_count = 0;

    always #5 clock = ~clock;

    queue_serializer #(.MSG_WIDTH(MW), .BEAT_WIDTH(BW), .RETRY_DELAY(RD)) dut (
        .clock     (clock),
        .reset     (reset),
        .q_data    (q_data),
        .q_valid   (q_valid),
        .q_pop     (q_pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .msg_count (msg_count)
`ifdef QUEUE_SERIALIZER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    queue_serializer #(.MSG_WIDTH(10), .BEAT_WIDTH(4), .RETRY_DELAY(3)) dut10 (
        .clock     (clock),
        .reset     (reset),
        .q_data    (q_data10),
        .q_valid   (q_valid10),
        .q_pop     (q_pop10),
        .out_data  (out_data10),
        .out_valid (out_valid10),
        .out_ready (out_ready10),
        .out_last  (out_last10),
        .busy      (busy10),
        .msg_count (msg_count10)
`ifdef QUEUE_SERIALIZER_PARITY_EN
        ,
        .out_parity(out_parity10)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Random traffic on inputs that must be ignored in the current state.
    task automatic junk();
        q_data  = 16'($urandom);
        q_valid = 1'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pop"},    q_pop,     0);
        chk({tag, "_valid"},  out_valid, 0);
        chk({tag, "_last"},   out_last,  0);
        chk({tag, "_busy"},   busy,      0);
        chk({tag, "_data"},   out_data,  0);
        chk({tag, "_count"},  msg_count, 0);
        chk({tag, "_pop10"},  q_pop10,   0);
        chk({tag, "_valid10"}, out_valid10, 0);
        chk({tag, "_data10"}, out_data10, 0);
        chk({tag, "_count10"}, msg_count10, 0);
`ifdef QUEUE_SERIALIZER_PARITY_EN
        chk({tag, "_parity"}, out_parity, 0);
`endif
    endtask

    // One pop attempt, entered in the cycle where q_pop must be high.
    // Expected beats come straight from the message value: beat k is
    // bits [k*BW +: BW], and the schedule follows REQ, WAIT, then either
    // the beats or RD backoff cycles.
    task automatic do_msg(input logic v, input logic [15:0] d, input bit rnd_ready,
                          input int stall_beat, input int stall_len);
        int         k;
        int         stalls;
        int         guard;
        logic [3:0] eb;

        junk();
        out_ready = 1'($urandom);
        @(negedge clock);
        chk("req_pop",   q_pop,     1);
        chk("req_valid", out_valid, 0);
        chk("req_count", msg_count, exp_count);
        tick();

        q_valid   = v;
        q_data    = d;
        out_ready = 1'($urandom);
        @(negedge clock);
        chk("wait_pop",   q_pop,     0);
        chk("wait_valid", out_valid, 0);
        tick();

        if (v) begin
            k      = 0;
            stalls = 0;
            guard  = 0;
            while (k < NB && guard < 200) begin
                junk();
                if (k == stall_beat && stalls < stall_len) begin
                    out_ready = 1'b0;
                    stalls++;
                end else if (rnd_ready) begin
                    out_ready = 1'($urandom);
                end else begin
                    out_ready = 1'b1;
                end
                eb = 4'((32'(d) >> (k * BW)) & 32'hF);
                @(negedge clock);
                chk("beat_valid", out_valid, 1);
                chk("beat_data",  out_data,  eb);
                chk("beat_last",  out_last,  (k == NB - 1));
                chk("beat_busy",  busy,      1);
                chk("beat_pop",   q_pop,     0);
                chk("beat_count", msg_count, exp_count);
`ifdef QUEUE_SERIALIZER_PARITY_EN
                chk("beat_parity", out_parity, ^eb);
`endif
                if (out_ready) begin
                    k++;
                    if (k == NB) exp_count = (exp_count + 1) % 65536;
                end
                guard++;
                tick();
            end
            if (k < NB) begin
                total++;
                bad++;
                $error("FAIL beat_budget observed=%0d expected=%0d", k, NB);
            end
        end else begin
            for (int b = 0; b < RD; b++) begin
                junk();
                out_ready = 1'($urandom);
                @(negedge clock);
                chk("backoff_pop",   q_pop,     0);
                chk("backoff_valid", out_valid, 0);
                chk("backoff_busy",  busy,      0);
                tick();
            end
        end
    endtask

    initial begin
        bit found;

        reset       = 1'b1;
        q_data      = '0;
        q_valid     = 1'b0;
        out_ready   = 1'b0;
        q_data10    = '0;
        q_valid10   = 1'b0;
        out_ready10 = 1'b0;

        // Reset held across several edges, all outputs 0.
        tick();
        @(negedge clock);
        chk_all_zero("rst_a");
        tick();
        @(negedge clock);
        chk_all_zero("rst_b");
        tick();
        reset = 1'b0;

        // First pop right after release; 16'hA5C3 gives 3, C, 5, A.
        do_msg(1'b1, 16'hA5C3, 1'b0, -1, 0);

        // Empty queue: pops spaced RD+2 cycles apart.
        do_msg(1'b0, 16'h0000, 1'b0, -1, 0);
        do_msg(1'b0, 16'h0000, 1'b0, -1, 0);
        do_msg(1'b0, 16'h0000, 1'b0, -1, 0);

        // Backpressure for 3 cycles on beat index 1.
        do_msg(1'b1, 16'hA5C3, 1'b0, 1, 3);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            do_msg(($urandom % 4) != 0, 16'($urandom), 1'b1, -1, 0);
        end

        // Reset after beat 0 is accepted: message dropped, not counted.
        junk();
        @(negedge clock);
        chk("mid_req_pop", q_pop, 1);
        tick();
        q_valid   = 1'b1;
        q_data    = 16'h1234;
        out_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("mid_beat0", out_data, 4'h4);
        tick();
        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        chk("mid_beat1", out_data, 4'h3);
        tick();
        @(negedge clock);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy",  busy,      0);
        chk("mid_rst_count", msg_count, 0);
        chk("mid_rst_pop",   q_pop,     0);
        tick();
        reset     = 1'b0;
        exp_count = 0;
        do_msg(1'b1, 16'hBEEF, 1'b0, -1, 0);

        // 10-bit instance: partial last beat. It has seen only empty pops.
        q_valid = 1'b0;
        found   = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clock);
            if (q_pop10) found = 1'b1;
            else tick();
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL sync10 observed=%0d expected=1", found);
        end
        tick();
        q_valid10   = 1'b1;
        q_data10    = 10'h3FF;
        out_ready10 = 1'b1;
        tick();
        q_valid10 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] eb10;
            eb10 = 4'((32'h3FF >> (k * 4)) & 32'hF);
            @(negedge clock);
            chk("w10_valid", out_valid10, 1);
            chk("w10_data",  out_data10,  eb10);
            chk("w10_last",  out_last10,  (k == 2));
`ifdef QUEUE_SERIALIZER_PARITY_EN
            chk("w10_parity", out_parity10, 0);
`endif
            tick();
        end
        @(negedge clock);
        chk("w10_pop",   q_pop10,     1);
        chk("w10_count", msg_count10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
